// File: rtl/des_link_pkg.sv
// Shared types and constants for the deserializer receive link controller.
package des_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    ACQ    = 2'd2,
    LOCKED = 2'd3
  } link_state_e;

  localparam logic [9:0] COMMA_P = 10'b0011111010;
  localparam logic [9:0] COMMA_N = 10'b1100000101;

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 6; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 4; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/des_link_ctrl_sym_check.sv
// Combinational classifier for one 10-bit code group: K28.5 comma and
// disparity-style code error (ones count of the 6b and 4b sub-blocks).
module des_sym_check
  import des_link_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_comma,
  output logic       code_err
);

  logic [2:0] hi_ones_s;
  logic [2:0] lo_ones_s;
  logic       hi_ok_s;
  logic       lo_ok_s;

  assign hi_ones_s = popcount6(sym[9:4]);
  assign lo_ones_s = popcount4(sym[3:0]);
  assign hi_ok_s   = (hi_ones_s >= 3'd2) && (hi_ones_s <= 3'd4);
  assign lo_ok_s   = (lo_ones_s >= 3'd1) && (lo_ones_s <= 3'd3);
  assign is_comma  = (sym == COMMA_P) || (sym == COMMA_N);
  assign code_err  = ~(hi_ok_s & lo_ok_s);

endmodule

// File: rtl/des_link_ctrl.sv
// Receive link controller: FIFO read sequencing, comma hunt/alignment, lock
// tracking. Define DES_LINK_CTRL_STATS_EN to build the comma/error statistics counters.
module des_link_ctrl
  import des_link_pkg::*;
#(
  parameter logic [3:0] ACQ_COMMAS = 4'd3,
  parameter logic [3:0] ERR_MAX    = 4'd4,
  parameter logic [3:0] GOOD_RUN   = 4'd4
) (
  input  logic        i_Rclk,
  input  logic        i_Rrst_n,
  input  logic        i_Enable,
  input  logic        i_Empty,
  input  logic        i_Bit,
  output logic        o_R_en,
  output logic [9:0]  o_Symbol,
  output logic        o_Sym_Valid,
  output logic        o_Is_Comma,
  output logic        o_Code_Err,
  output logic        o_Locked,
  output logic [15:0] o_Comma_Cnt,
  output logic [15:0] o_Err_Cnt
);

  link_state_e state_r, state_nxt_s;
  logic        rd_pend_r;
  logic [9:0]  win_r, win_nxt_s, win_shift_s;
  logic [3:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [3:0]  acq_cnt_r, acq_cnt_nxt_s;
  logic [3:0]  err_cnt_r, err_cnt_nxt_s;
  logic [3:0]  good_cnt_r, good_cnt_nxt_s;
  logic [9:0]  sym_r, sym_nxt_s;
  logic        sym_vld_r, sym_vld_nxt_s;
  logic        comma_r, comma_nxt_s;
  logic        cerr_r, cerr_nxt_s;
  logic        r_en_s, capture_s, sym_done_s, emit_s;
  logic        chk_comma_s, chk_err_s;
  logic [3:0]  acq_inc_s, err_inc_s, good_inc_s;

  assign r_en_s      = i_Enable & ~i_Empty & (state_r != IDLE);
  // A bit read just before dropping to IDLE is thrown away.
  assign capture_s   = rd_pend_r & i_Enable & (state_r != IDLE);
  assign win_shift_s = {i_Bit, win_r[9:1]};
  assign sym_done_s  = capture_s & (bit_cnt_r == 4'd9);
  assign acq_inc_s   = acq_cnt_r + 4'd1;
  assign err_inc_s   = err_cnt_r + 4'd1;
  assign good_inc_s  = good_cnt_r + 4'd1;

  des_sym_check u_sym_check (
    .sym      (win_shift_s),
    .is_comma (chk_comma_s),
    .code_err (chk_err_s)
  );

  // Next-state, counter and symbol-output logic.
  always_comb begin
    state_nxt_s    = state_r;
    win_nxt_s      = win_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    acq_cnt_nxt_s  = acq_cnt_r;
    err_cnt_nxt_s  = err_cnt_r;
    good_cnt_nxt_s = good_cnt_r;
    sym_nxt_s      = sym_r;
    sym_vld_nxt_s  = 1'b0;
    comma_nxt_s    = 1'b0;
    cerr_nxt_s     = 1'b0;
    emit_s         = 1'b0;
    if (!i_Enable) begin
      state_nxt_s    = IDLE;
      win_nxt_s      = 10'h000;
      bit_cnt_nxt_s  = 4'd0;
      acq_cnt_nxt_s  = 4'd0;
      err_cnt_nxt_s  = 4'd0;
      good_cnt_nxt_s = 4'd0;
      sym_nxt_s      = 10'h000;
    end else begin
      if (capture_s) begin
        win_nxt_s = win_shift_s;
      end else begin
        win_nxt_s = win_r;
      end
      case (state_r)
        IDLE: begin
          state_nxt_s = HUNT;
        end
        HUNT: begin
          if (capture_s && chk_comma_s) begin
            emit_s        = 1'b1;
            bit_cnt_nxt_s = 4'd0;
            acq_cnt_nxt_s = 4'd1;
            if (ACQ_COMMAS == 4'd1) begin
              state_nxt_s    = LOCKED;
              acq_cnt_nxt_s  = 4'd0;
              err_cnt_nxt_s  = 4'd0;
              good_cnt_nxt_s = 4'd0;
            end else begin
              state_nxt_s = ACQ;
            end
          end else begin
            state_nxt_s = HUNT;
          end
        end
        ACQ: begin
          if (sym_done_s) begin
            emit_s        = 1'b1;
            bit_cnt_nxt_s = 4'd0;
            if (chk_err_s) begin
              state_nxt_s   = HUNT;
              acq_cnt_nxt_s = 4'd0;
            end else if (chk_comma_s) begin
              if (acq_inc_s == ACQ_COMMAS) begin
                state_nxt_s    = LOCKED;
                acq_cnt_nxt_s  = 4'd0;
                err_cnt_nxt_s  = 4'd0;
                good_cnt_nxt_s = 4'd0;
              end else begin
                acq_cnt_nxt_s = acq_inc_s;
              end
            end else begin
              acq_cnt_nxt_s = acq_cnt_r;
            end
          end else if (capture_s) begin
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end
        LOCKED: begin
          if (sym_done_s) begin
            emit_s        = 1'b1;
            bit_cnt_nxt_s = 4'd0;
            if (chk_err_s) begin
              good_cnt_nxt_s = 4'd0;
              if (err_inc_s == ERR_MAX) begin
                state_nxt_s   = HUNT;
                err_cnt_nxt_s = 4'd0;
              end else begin
                err_cnt_nxt_s = err_inc_s;
              end
            end else if (good_inc_s == GOOD_RUN) begin
              good_cnt_nxt_s = 4'd0;
              if (err_cnt_r != 4'd0) begin
                err_cnt_nxt_s = err_cnt_r - 4'd1;
              end else begin
                err_cnt_nxt_s = err_cnt_r;
              end
            end else begin
              good_cnt_nxt_s = good_inc_s;
            end
          end else if (capture_s) begin
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
      if (emit_s) begin
        sym_nxt_s     = win_shift_s;
        sym_vld_nxt_s = 1'b1;
        comma_nxt_s   = chk_comma_s;
        cerr_nxt_s    = chk_err_s;
      end else begin
        sym_vld_nxt_s = 1'b0;
      end
    end
  end

  // State, window, counters and registered symbol outputs.
  always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
    if (!i_Rrst_n) begin
      state_r    <= IDLE;
      rd_pend_r  <= 1'b0;
      win_r      <= 10'h000;
      bit_cnt_r  <= 4'd0;
      acq_cnt_r  <= 4'd0;
      err_cnt_r  <= 4'd0;
      good_cnt_r <= 4'd0;
      sym_r      <= 10'h000;
      sym_vld_r  <= 1'b0;
      comma_r    <= 1'b0;
      cerr_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rd_pend_r  <= r_en_s;
      win_r      <= win_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      acq_cnt_r  <= acq_cnt_nxt_s;
      err_cnt_r  <= err_cnt_nxt_s;
      good_cnt_r <= good_cnt_nxt_s;
      sym_r      <= sym_nxt_s;
      sym_vld_r  <= sym_vld_nxt_s;
      comma_r    <= comma_nxt_s;
      cerr_r     <= cerr_nxt_s;
    end
  end

  assign o_R_en      = r_en_s;
  assign o_Symbol    = sym_r;
  assign o_Sym_Valid = sym_vld_r;
  assign o_Is_Comma  = comma_r;
  assign o_Code_Err  = cerr_r;
  assign o_Locked    = (state_r == LOCKED);

`ifdef DES_LINK_CTRL_STATS_EN
  logic [15:0] comma_stat_r;
  logic [15:0] err_stat_r;

  // Saturating statistics, counted on the edge that registers each strobe.
  always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
    if (!i_Rrst_n) begin
      comma_stat_r <= 16'h0000;
      err_stat_r   <= 16'h0000;
    end else begin
      if (sym_vld_nxt_s && comma_nxt_s && (comma_stat_r != 16'hFFFF)) begin
        comma_stat_r <= comma_stat_r + 16'h0001;
      end
      if (sym_vld_nxt_s && cerr_nxt_s && (err_stat_r != 16'hFFFF)) begin
        err_stat_r <= err_stat_r + 16'h0001;
      end
    end
  end

  assign o_Comma_Cnt = comma_stat_r;
  assign o_Err_Cnt   = err_stat_r;
`else
  assign o_Comma_Cnt = 16'h0000;
  assign o_Err_Cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_des_link_ctrl.sv
// Directed bench for des_link_ctrl: a bit-queue FIFO model feeds the link and
// every symbol strobe is compared against a hand-written expectation list.
module tb_des_link_ctrl;

  logic        i_Rclk = 1'b0;
  logic        i_Rrst_n, i_Enable, i_Empty, i_Bit;
  logic        o_R_en, o_Sym_Valid, o_Is_Comma, o_Code_Err, o_Locked;
  logic [9:0]  o_Symbol;
  logic [15:0] o_Comma_Cnt, o_Err_Cnt;

`ifdef DES_LINK_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [9:0] CP = 10'b0011111010;
  localparam logic [9:0] V1 = 10'h155;
  localparam logic [9:0] V2 = 10'h2AA;
  localparam logic [9:0] V3 = 10'h0F3;
  localparam logic [9:0] BAD = 10'h3FF;

  always #5 i_Rclk = ~i_Rclk;

  des_link_ctrl #(.ACQ_COMMAS(4'd3), .ERR_MAX(4'd4), .GOOD_RUN(4'd4)) dut (
    .i_Rclk(i_Rclk), .i_Rrst_n(i_Rrst_n), .i_Enable(i_Enable), .i_Empty(i_Empty),
    .i_Bit(i_Bit), .o_R_en(o_R_en), .o_Symbol(o_Symbol), .o_Sym_Valid(o_Sym_Valid),
    .o_Is_Comma(o_Is_Comma), .o_Code_Err(o_Code_Err), .o_Locked(o_Locked),
    .o_Comma_Cnt(o_Comma_Cnt), .o_Err_Cnt(o_Err_Cnt)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  logic        fifo[$];
  logic [12:0] exp_q[$];
  logic        ren_prev = 1'b0;
  logic        gap_mode = 1'b0;
  logic        gap_tog = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) fifo.push_back(s[i]);
  endtask

  // {locked, code_err, is_comma, symbol}
  task automatic expect_sym(input logic lk, input logic er, input logic cm, input logic [9:0] s);
    exp_q.push_back({lk, er, cm, s});
  endtask

  // One clock: entered and left #1 after a rising edge.
  task automatic cyc();
    logic [12:0] e;
    gap_tog = ~gap_tog;
    i_Empty = (fifo.size() == 0) || (gap_mode && gap_tog);
    @(negedge i_Rclk);
    ren_prev = o_R_en;
    if (o_Sym_Valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", 32'(o_Sym_Valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("symbol", {19'd0, o_Locked, o_Code_Err, o_Is_Comma, o_Symbol}, {19'd0, e});
      end
    end
    @(posedge i_Rclk);
    #1;
    if (ren_prev) i_Bit = (fifo.size() > 0) ? fifo.pop_front() : 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && k < budget) begin
      cyc();
      k++;
    end
    repeat (4) cyc();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_Rrst_n = 1'b0; i_Enable = 1'b0; i_Empty = 1'b1; i_Bit = 1'b0;
    #12;
    chk("rst_symbol", 32'(o_Symbol), 32'd0);
    chk("rst_flags", {27'd0, o_R_en, o_Sym_Valid, o_Is_Comma, o_Code_Err, o_Locked}, 32'd0);
    chk("rst_stats", {o_Comma_Cnt, o_Err_Cnt}, 32'd0);
    @(negedge i_Rclk);
    i_Rrst_n = 1'b1;
    @(posedge i_Rclk);
    #1;
    i_Enable = 1'b1;
    repeat (3) cyc();
    chk("empty_ren", 32'(o_R_en), 32'd0);
    chk("hunt_unlocked", 32'(o_Locked), 32'd0);

    // Hunt: alternating filler, comma at a 33-bit offset, two more commas.
    repeat (3) push_sym(V1);
    fifo.push_back(1'b1); fifo.push_back(1'b0); fifo.push_back(1'b1);
    push_sym(CP); push_sym(CP); push_sym(CP); push_sym(V1); push_sym(V2);
    i_Empty = 1'b0;
    #1;
    chk("hunt_ren", 32'(o_R_en), 32'd1);
    expect_sym(1'b0, 1'b0, 1'b1, CP);
    expect_sym(1'b0, 1'b0, 1'b1, CP);
    expect_sym(1'b1, 1'b0, 1'b1, CP);
    expect_sym(1'b1, 1'b0, 1'b0, V1);
    expect_sym(1'b1, 1'b0, 1'b0, V2);
    drain("acq_left", 300);
    chk("sym_hold", 32'(o_Symbol), 32'(V2));
    chk("comma_stat", 32'(o_Comma_Cnt), STATS ? 32'd3 : 32'd0);

    // Four errors separated by two good symbols: loses lock on the 4th.
    for (int i = 0; i < 4; i++) begin
      push_sym(BAD);
      expect_sym((i == 3) ? 1'b0 : 1'b1, 1'b1, 1'b0, BAD);
      if (i != 3) begin
        push_sym(V1); push_sym(V1);
        expect_sym(1'b1, 1'b0, 1'b0, V1);
        expect_sym(1'b1, 1'b0, 1'b0, V1);
      end
    end
    drain("drop_left", 400);
    chk("drop_unlocked", 32'(o_Locked), 32'd0);
    chk("err_stat", 32'(o_Err_Cnt), STATS ? 32'd4 : 32'd0);

    // Relock, then error / 4 good / error / 4 good / error stays locked.
    push_sym(CP); push_sym(CP); push_sym(CP);
    expect_sym(1'b0, 1'b0, 1'b1, CP);
    expect_sym(1'b0, 1'b0, 1'b1, CP);
    expect_sym(1'b1, 1'b0, 1'b1, CP);
    for (int i = 0; i < 3; i++) begin
      push_sym(BAD);
      expect_sym(1'b1, 1'b1, 1'b0, BAD);
      if (i != 2) begin
        for (int j = 0; j < 4; j++) begin
          push_sym(V1);
          expect_sym(1'b1, 1'b0, 1'b0, V1);
        end
      end
    end
    drain("run_left", 500);
    chk("run_locked", 32'(o_Locked), 32'd1);

    // FIFO empty on alternate cycles.
    gap_mode = 1'b1;
    push_sym(V3); push_sym(V2);
    expect_sym(1'b1, 1'b0, 1'b0, V3);
    expect_sym(1'b1, 1'b0, 1'b0, V2);
    drain("gap_left", 300);
    gap_mode = 1'b0;
    chk("gap_hold", 32'(o_Symbol), 32'(V2));

    // Enable dropped mid-symbol.
    push_sym(V1);
    repeat (4) cyc();
    i_Enable = 1'b0;
    #1;
    chk("dis_ren", 32'(o_R_en), 32'd0);
    @(posedge i_Rclk);
    #1;
    i_Enable = 1'b1;
    fifo.delete();
    ren_prev = 1'b0;
    chk("dis_lock", 32'(o_Locked), 32'd0);
    chk("dis_idle_ren", 32'(o_R_en), 32'd0);
    push_sym(V1); push_sym(V2);
    drain("reen_left", 100);
    chk("reen_unlocked", 32'(o_Locked), 32'd0);
    push_sym(CP); push_sym(CP); push_sym(CP); push_sym(V1);
    expect_sym(1'b0, 1'b0, 1'b1, CP);
    expect_sym(1'b0, 1'b0, 1'b1, CP);
    expect_sym(1'b1, 1'b0, 1'b1, CP);
    expect_sym(1'b1, 1'b0, 1'b0, V1);
    drain("relock_left", 300);

    // Asynchronous reset mid-symbol.
    push_sym(V2);
    repeat (4) cyc();
    #2;
    i_Rrst_n = 1'b0;
    #1;
    chk("arst_symbol", 32'(o_Symbol), 32'd0);
    chk("arst_flags", {27'd0, o_R_en, o_Sym_Valid, o_Is_Comma, o_Code_Err, o_Locked}, 32'd0);
    chk("arst_stats", {o_Comma_Cnt, o_Err_Cnt}, 32'd0);
    fifo.delete();
    exp_q.delete();
    @(negedge i_Rclk);
    i_Rrst_n = 1'b1;
    @(posedge i_Rclk);
    #1;
    ren_prev = 1'b0;
    repeat (3) cyc();
    chk("post_rst_unlocked", 32'(o_Locked), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/des_link_ctrl.md
# des_link_ctrl

Receive-side link controller that sequences the deserializer's async FIFO read path. It issues read enables, assembles the serial bit stream into 10-bit symbols and hunts for the K28.5 comma to establish symbol alignment. It then tracks code-group validity to declare and drop lock. It sits between the async FIFO read port and the 8b/10b decode stage, and delivers aligned symbols with a valid strobe.

## Interface
- ACQ_COMMAS, 3: aligned commas required in ACQ to enter LOCKED (1..15).
- ERR_MAX, 4: error-counter value that drops LOCKED back to HUNT (1..15).
- GOOD_RUN, 4: consecutive valid symbols that decrement the error counter by 1 (1..15).
- i_Rclk  in  1  read-domain clock; sole clock.
- i_Rrst_n  in  1  asynchronous, active-low reset.
- i_Enable  in  1  link enable; low forces IDLE.
- i_Empty  in  1  FIFO empty flag.
- i_Bit  in  1  FIFO data out; valid the cycle after o_R_en was high.
- o_R_en  out  1  FIFO read enable.
- o_Symbol  out  10  aligned symbol; first-received bit in [0].
- o_Sym_Valid  out  1  one-cycle strobe, o_Symbol valid.
- o_Is_Comma  out  1  qualifies o_Sym_Valid; the symbol is K28.5.
- o_Code_Err  out  1  qualifies o_Sym_Valid; the symbol is invalid.
- o_Locked  out  1  high in LOCKED.
- o_Comma_Cnt  out  16  commas seen (see Configuration).
- o_Err_Cnt  out  16  code errors seen (see Configuration).

## Operation
- The window W[9:0] is a shift register. Each captured bit enters W[9] and shifts W right, so the first-received bit ends up in [0].
- Comma: W == COMMA_P (10'b0011111010) or COMMA_N (10'b1100000101).
- Valid symbol: popcount(W[9:4]) in {2,3,4} and popcount(W[3:0]) in {1,2,3}. Any other symbol is a code error.
- States: IDLE, HUNT, ACQ, LOCKED.
- IDLE:
  - Entered on reset, or whenever i_Enable is low (this overrides all other transitions).
  - Leaves to HUNT when i_Enable is high.
- HUNT:
  - Checks W after every captured bit.
  - On a comma: emit W as a symbol with o_Is_Comma=1, clear the bit counter, set the ACQ comma count to 1, go to ACQ.
  - If ACQ_COMMAS==1, go directly to LOCKED.
- ACQ:
  - Emits a symbol every 10 captured bits.
  - A comma symbol increments the comma count; reaching ACQ_COMMAS moves to LOCKED.
  - A code error returns to HUNT with counts cleared.
  - Non-comma valid symbols are allowed and do not change the count.
- LOCKED:
  - A code error increments the 4-bit error counter and clears the good-run counter.
  - Each valid symbol increments the good-run counter. When it reaches GOOD_RUN, decrement the error counter if it is non-zero, and clear the good-run counter.
  - When the error counter reaches ERR_MAX, go to HUNT and clear both counters.
  - Commas do not realign while LOCKED.
- o_R_en = i_Enable & ~i_Empty & (state != IDLE).
- Every read returns exactly one bit, captured the next cycle.
- Leaving IDLE: an in-flight bit read before entry to IDLE is discarded, not captured.

## Timing
- Reset (asynchronous): state=IDLE; W, all counters and the bit counter are 0. All outputs are 0, including o_Symbol=10'h000.
- o_R_en is combinational from i_Empty, i_Enable and the registered state.
- Bit capture happens on the edge after the cycle in which o_R_en was high. W is updated on that edge.
- o_Sym_Valid rises the cycle after the edge that captured the 10th bit, or the comma-completing bit in HUNT. It lasts exactly one cycle.
- o_Symbol holds its value until the next strobe.
- The error counter, o_Locked and state update on the same edge that registers o_Sym_Valid. In LOCKED, for example, o_Locked falls in the same cycle o_Code_Err pulses for the ERR_MAX-th error.
- When the FIFO is empty, no bit is captured, so the bit counter stalls. Gaps in the stream never produce partial symbols.
- Minimum symbol period is 10 cycles. Maximum throughput is one bit per cycle.
- i_Enable low for one cycle: the state goes to IDLE on the next edge, counters clear, and o_Locked falls that edge.

## Configuration
- DES_LINK_CTRL_STATS_EN defined:
  - o_Comma_Cnt increments on every symbol strobe with o_Is_Comma.
  - o_Err_Cnt increments on every strobe with o_Code_Err.
  - Both are 16-bit and saturate at 16'hFFFF.
  - Both are cleared only by reset.
- Macro undefined: both ports are present and driven to constant 0, and no counter flops are generated.

## Structure
- Package des_link_pkg: the state enum (IDLE, HUNT, ACQ, LOCKED) and the COMMA_P/COMMA_N constants.
- Sub-module des_sym_check: combinational. Takes a 10-bit input and produces is_comma and code_err (the popcount rules above).

## Test plan
- Reset, i_Enable=1, i_Empty=1 -> o_R_en=0, state HUNT, no o_Sym_Valid.
- Three random valid symbols, then 0011111010 on an arbitrary bit offset, then two aligned commas -> first comma strobe carries o_Is_Comma=1. o_Locked=1 on the third comma strobe; the symbols after it are emitted aligned.
- Locked, 4 invalid symbols (e.g. 10'h3FF) separated by 2 valid symbols each -> o_Locked falls on the 4th error strobe. o_Err_Cnt=4 with STATS_EN.
- Locked, error, 4 valid, error, 4 valid, error -> stays locked (counter 1,0,1,0,1).
- i_Empty toggling every other cycle during a symbol -> one strobe per 10 captured bits; o_Symbol matches the sent pattern.
- Mid-symbol i_Enable low, and separately i_Rrst_n low -> IDLE / all-zero outputs at once. Re-enable requires a new comma to lock.
